// File: rtl/led_scan_pwm_if.sv
// Control and status bundle between the LED scanner and its driver.
// No latency of its own; it carries wires only.
// No backpressure: step is a fire-and-forget strobe, outputs are free-running.
interface led_scan_pwm_if #(
   parameter int LEDS = 8
);
   localparam int PW = $clog2(LEDS);

   logic            step;
   logic            enable;
   logic [LEDS-1:0] LED;
   logic [PW-1:0]   pos;
   logic            dir;
   logic            frame;

   // Driver side: issues step/enable, observes the LED stage.
   modport master (
      output step, enable,
      input  LED, pos, dir, frame
   );

   // LED stage side.
   modport slave (
      input  step, enable,
      output LED, pos, dir, frame
   );
endinterface

// File: rtl/led_scan_pwm.sv
// PWM-dimmed bouncing-dot LED scanner with a decaying tail, advanced by step strobes.
// LED outputs are registered, one cycle behind pwm_cnt; pattern advances only at frame ends.
// No backpressure: steps within one frame coalesce, steps while disabled are dropped.
module led_scan_pwm #(
   parameter int LEDS        = 8,
   parameter int PWM_BITS    = 8,
   parameter int DECAY_SHIFT = 1
) (
   input  logic         clk_in,
   input  logic         rst,
   led_scan_pwm_if.slave bus
);
   localparam int                PW      = $clog2(LEDS);
   localparam logic [PW-1:0]     LAST    = PW'(LEDS - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;

   typedef enum logic {
      LEFT  = 1'b0,
      RIGHT = 1'b1
   } scan_e;

   scan_e               state_q, state_d;
   logic [PW-1:0]       pos_q, pos_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic                pending_q, pending_d;
   logic [PWM_BITS-1:0] bri_q [LEDS];
   logic [PWM_BITS-1:0] bri_d [LEDS];
   logic [LEDS-1:0]     led_q, led_d;
   logic                frame_w;
   logic                apply_w;

   // Frame end only counts while running, so a held counter at max does not re-fire.
   assign frame_w = bus.enable && (pwm_cnt_q == PWM_MAX);
   assign apply_w = frame_w && pending_q;

   assign bus.LED   = led_q;
   assign bus.pos   = pos_q;
   assign bus.dir   = (state_q == RIGHT);
   assign bus.frame = frame_w;

   // Scan FSM state and dot position register.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         state_q <= RIGHT;
         pos_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_q   <= pos_d;
      end
   end

   // Next dot position: bounce at the ends without dwelling there for a second step.
   always_comb begin
      state_d = state_q;
      pos_d   = pos_q;
      if (apply_w) begin
         case (state_q)
            RIGHT: begin
               if (pos_q == LAST) begin
                  state_d = LEFT;
                  pos_d   = LAST - 1'b1;
               end else begin
                  pos_d = pos_q + 1'b1;
               end
            end
            LEFT: begin
               if (pos_q == '0) begin
                  state_d = RIGHT;
                  pos_d   = PW'(1);
               end else begin
                  pos_d = pos_q - 1'b1;
               end
            end
            default: begin
               state_d = RIGHT;
               pos_d   = '0;
            end
         endcase
      end
   end

   // PWM counter, step capture, brightness decay/refresh and LED comparator.
   always_comb begin
      pwm_cnt_d = pwm_cnt_q;
      pending_d = pending_q;
      for (int i = 0; i < LEDS; i++) begin
         bri_d[i] = bri_q[i];
      end
      if (!bus.enable) begin
         pending_d = 1'b0;
      end else begin
         pwm_cnt_d = pwm_cnt_q + 1'b1;
         if (apply_w) begin
            // A step landing on the apply cycle itself belongs to the next frame.
            pending_d = bus.step;
            for (int i = 0; i < LEDS; i++) begin
               if (pos_d == PW'(i)) begin
                  bri_d[i] = '1;
               end else begin
                  bri_d[i] = bri_q[i] >> DECAY_SHIFT;
               end
            end
         end else if (bus.step) begin
            pending_d = 1'b1;
         end
      end
      for (int i = 0; i < LEDS; i++) begin
         led_d[i] = bus.enable && (bri_q[i] > pwm_cnt_q);
      end
   end

   // Datapath registers; reset lights only LED 0 at full brightness.
   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         pwm_cnt_q <= '0;
         pending_q <= 1'b0;
         led_q     <= '0;
         for (int i = 0; i < LEDS; i++) begin
            bri_q[i] <= (i == 0) ? '1 : '0;
         end
      end else begin
         pwm_cnt_q <= pwm_cnt_d;
         pending_q <= pending_d;
         led_q     <= led_d;
         for (int i = 0; i < LEDS; i++) begin
            bri_q[i] <= bri_d[i];
         end
      end
   end
endmodule
